// File: rtl/affine_iter_ctrl_pkg.sv
// rtl/affine_iter_ctrl_pkg.sv - shared types and lane helpers for the affine iteration controller
package affine_ctrl_pkg;

   localparam int N_LANE = 3;
   localparam int N_ELEM = 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_t;

   // Bit offset of lane 'lane' in a packed vector of 'w'-bit lanes (lane 0 in the LSBs).
   function automatic int lane_lo(input int lane, input int w);
      return lane * w;
   endfunction

   // Bit offset of matrix element (row, col) in a row-major packed matrix (A00 in the LSBs).
   function automatic int elem_lo(input int row, input int col, input int w);
      return (row * N_LANE + col) * w;
   endfunction

endpackage

// File: rtl/affine_iter_ctrl_if.sv
// rtl/affine_iter_ctrl_if.sv - control, datapath and emit signals of the affine iteration controller
interface affine_iter_ctrl_if import affine_ctrl_pkg::*; #(
   parameter int PRECISION = 32,
   parameter int CNT_W     = 16
);

   logic                        start;
   logic                        abort;
   logic [N_ELEM*PRECISION-1:0] a_mat;
   logic [N_LANE*PRECISION-1:0] u_vec;
   logic [N_LANE*PRECISION-1:0] x_init;
   logic [CNT_W-1:0]            n_warmup;
   logic [CNT_W-1:0]            n_iter;
   logic                        dp_tvalid;
   logic [N_ELEM*PRECISION-1:0] dp_a_mat;
   logic [N_LANE*PRECISION-1:0] dp_u;
   logic [N_LANE*PRECISION-1:0] dp_x;
   logic                        dp_valid;
   logic [N_LANE*PRECISION-1:0] dp_x_next;
   logic                        out_valid;
   logic                        out_ready;
   logic [N_LANE*PRECISION-1:0] out_x;
   logic [CNT_W-1:0]            out_idx;
   logic                        busy;
   logic                        done;
   logic                        err_timeout;

   // Controller side.
   modport master (
      input  start, abort, a_mat, u_vec, x_init, n_warmup, n_iter,
             dp_valid, dp_x_next, out_ready,
      output dp_tvalid, dp_a_mat, dp_u, dp_x, out_valid, out_x, out_idx,
             busy, done, err_timeout
   );

   // Environment side: configuration source, datapath and consumer.
   modport slave (
      output start, abort, a_mat, u_vec, x_init, n_warmup, n_iter,
             dp_valid, dp_x_next, out_ready,
      input  dp_tvalid, dp_a_mat, dp_u, dp_x, out_valid, out_x, out_idx,
             busy, done, err_timeout
   );

endinterface

// File: rtl/affine_iter_ctrl.sv
// rtl/affine_iter_ctrl.sv - sequences warm-up and emitted iterations of an external affine datapath
module affine_iter_ctrl import affine_ctrl_pkg::*; #(
   parameter int PRECISION = 32,
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 64
) (
   input logic          clk,
   input logic          reset,
   affine_iter_ctrl_if.master bus
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t                      state;
   logic [N_ELEM*PRECISION-1:0] a_reg;
   logic [N_LANE*PRECISION-1:0] u_reg;
   logic [N_LANE*PRECISION-1:0] x_reg;
   logic [CNT_W-1:0]            nw_reg;
   logic [CNT_W-1:0]            ni_reg;
   logic [CNT_W-1:0]            emit_cnt;
   // One bit wider so warm-up plus emitted iterations never wraps.
   logic [CNT_W:0]              tot_cnt;
   logic [WD_W-1:0]             wd_cnt;
   logic                        dp_tvalid_r;
   logic                        out_valid_r;
   logic                        busy_r;
   logic                        done_r;
   logic                        err_r;

   logic [CNT_W:0]              tot_nxt;
   logic [CNT_W-1:0]            emit_nxt;

   assign tot_nxt  = tot_cnt + (CNT_W+1)'(1);
   assign emit_nxt = emit_cnt + CNT_W'(1);

   assign bus.dp_tvalid   = dp_tvalid_r;
   assign bus.dp_a_mat    = a_reg;
   assign bus.dp_u        = u_reg;
   assign bus.dp_x        = x_reg;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_x       = x_reg;
   assign bus.out_idx     = emit_cnt;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.err_timeout = err_r;

   // Run FSM with registered strobes; abort outranks every event in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         a_reg       <= '0;
         u_reg       <= '0;
         x_reg       <= '0;
         nw_reg      <= '0;
         ni_reg      <= '0;
         emit_cnt    <= '0;
         tot_cnt     <= '0;
         wd_cnt      <= '0;
         dp_tvalid_r <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else if (bus.abort) begin
         state       <= S_IDLE;
         dp_tvalid_r <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_reg    <= bus.a_mat;
                  u_reg    <= bus.u_vec;
                  x_reg    <= bus.x_init;
                  nw_reg   <= bus.n_warmup;
                  ni_reg   <= bus.n_iter;
                  emit_cnt <= '0;
                  tot_cnt  <= '0;
                  err_r    <= 1'b0;
                  busy_r   <= 1'b1;
                  if (bus.n_iter == '0) begin
                     state <= S_DONE;
                  end else begin
                     state       <= S_ISSUE;
                     dp_tvalid_r <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               dp_tvalid_r <= 1'b0;
               // The issue cycle itself counts toward the watchdog.
               wd_cnt      <= WD_W'(1);
               state       <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.dp_valid) begin
                  x_reg   <= bus.dp_x_next;
                  tot_cnt <= tot_nxt;
                  if (tot_nxt <= {1'b0, nw_reg}) begin
                     state       <= S_ISSUE;
                     dp_tvalid_r <= 1'b1;
                  end else begin
                     state       <= S_EMIT;
                     out_valid_r <= 1'b1;
                  end
               end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                  err_r  <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            S_EMIT: begin
               if (bus.out_ready) begin
                  emit_cnt    <= emit_nxt;
                  out_valid_r <= 1'b0;
                  if (emit_nxt == ni_reg) begin
                     state <= S_DONE;
                  end else begin
                     state       <= S_ISSUE;
                     dp_tvalid_r <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_affine_iter_ctrl.sv
// tb/tb_affine_iter_ctrl.sv - self-checking bench for affine_iter_ctrl
module tb_affine_iter_ctrl;
   import affine_ctrl_pkg::*;

   typedef logic [287:0] amat_t;
   typedef logic [95:0]  vec_t;

   typedef struct {
      amat_t a;
      vec_t  u;
      vec_t  x;
      int    nw;
      int    ni;
      int    pct;
      vec_t  exp_last;
      int    exp_tv;
   } vec_rec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_total = 0;
   int   n_bad = 0;

   bit    stub_on;
   bit    stub_junk;
   int    stub_lat;
   bit    pend;
   int    cd;
   bit    real_v;
   amat_t sa;
   vec_t  su;
   vec_t  sx;

   affine_iter_ctrl_if #(.PRECISION(32), .CNT_W(16)) bus ();

   affine_iter_ctrl #(.PRECISION(32), .CNT_W(16), .TIMEOUT(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL global_time_limit got=running want=finished");
      $fatal(1, "time limit");
   end

   function automatic vec_t mk_vec(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2);
      return {l2, l1, l0};
   endfunction

   function automatic amat_t set_e(input amat_t a, input int r, input int c, input logic [31:0] v);
      amat_t t = a;
      t[elem_lo(r, c, 32) +: 32] = v;
      return t;
   endfunction

   // Reference: x_next[i] = sum_j A[i][j]*x[j] + U[i], modulo 2^32 per lane.
   function automatic vec_t affine(input amat_t a, input vec_t u, input vec_t x);
      vec_t r;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] acc = u[lane_lo(i, 32) +: 32];
         for (int j = 0; j < 3; j++) begin
            logic [31:0] ae = a[elem_lo(i, j, 32) +: 32];
            logic [31:0] xe = x[lane_lo(j, 32) +: 32];
            acc = acc + ae * xe;
         end
         r[lane_lo(i, 32) +: 32] = acc;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, exp);
      end
   endtask

   // One cycle: move to the falling edge, then play the datapath for that cycle.
   task automatic tick();
      @(negedge clk);
      bus.dp_valid = 1'b0;
      real_v = 1'b0;
      if (reset) begin
         pend = 1'b0;
      end else if (stub_on) begin
         if (pend) chk("dp_x_stable", 128'(bus.dp_x), 128'(sx));
         if (bus.dp_tvalid) begin
            pend = 1'b1;
            cd = stub_lat;
            sa = bus.dp_a_mat;
            su = bus.dp_u;
            sx = bus.dp_x;
         end else if (pend) begin
            if (cd == 0) begin
               bus.dp_valid  = 1'b1;
               bus.dp_x_next = affine(sa, su, sx);
               pend = 1'b0;
               real_v = 1'b1;
            end else begin
               cd--;
            end
         end else if (stub_junk) begin
            bus.dp_valid  = 1'b1;
            bus.dp_x_next = {$urandom, $urandom, $urandom};
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_dp_tvalid"}, 128'(bus.dp_tvalid), 128'(0));
      chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
      chk({tag, "_done"}, 128'(bus.done), 128'(0));
      chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
      chk({tag, "_err"}, 128'(bus.err_timeout), 128'(0));
      chk({tag, "_out_idx"}, 128'(bus.out_idx), 128'(0));
      chk({tag, "_out_x"}, 128'(bus.out_x), 128'(0));
      chk({tag, "_dp_a"}, 128'(bus.dp_a_mat[127:0]), 128'(0));
   endtask

   task automatic run_one(input amat_t a, input vec_t u, input vec_t x, input int nw, input int ni,
                          input int pct, output vec_t last_x, output int n_out, output int n_tv,
                          output int n_done);
      vec_t exp_q[$];
      vec_t m = x;
      vec_t prev_x = '0;
      logic [15:0] prev_idx = '0;
      bit ov_prev = 0, exp_tv = 0, exp_ov = 0, fin = 0;
      int cyc = 0, k = 0, hs_cyc = -1;
      for (int i = 1; i <= nw + ni; i++) begin
         m = affine(a, u, m);
         if (i > nw) exp_q.push_back(m);
      end
      last_x = '0; n_out = 0; n_tv = 0; n_done = 0;
      bus.a_mat = a; bus.u_vec = u; bus.x_init = x;
      bus.n_warmup = 16'(nw); bus.n_iter = 16'(ni);
      bus.out_ready = 1'b0; bus.start = 1'b1;
      while (!fin && cyc < 4000) begin
         tick();
         cyc++;
         bus.start = 1'b0;
         if (cyc == 1) begin
            chk("first_tv", 128'(bus.dp_tvalid), 128'(ni != 0));
            chk("err_cleared", 128'(bus.err_timeout), 128'(0));
         end
         if (exp_tv) chk("tv_spacing", 128'(bus.dp_tvalid), 128'(1));
         if (exp_ov) chk("ov_spacing", 128'(bus.out_valid), 128'(1));
         exp_tv = 0; exp_ov = 0;
         if (bus.dp_tvalid) n_tv++;
         if (ov_prev && bus.out_valid) begin
            chk("hold_x", 128'(bus.out_x), 128'(prev_x));
            chk("hold_idx", 128'(bus.out_idx), 128'(prev_idx));
            chk("no_tv_in_emit", 128'(bus.dp_tvalid), 128'(0));
         end
         if (bus.done) begin
            n_done++;
            chk("done_lat", 128'(cyc), 128'(ni == 0 ? 2 : hs_cyc + 2));
            chk("busy_at_done", 128'(bus.busy), 128'(0));
            fin = 1;
         end
         if (bus.err_timeout) fin = 1;
         if (real_v) begin
            k++;
            if (k <= nw) exp_tv = 1;
            else exp_ov = 1;
         end
         if (!fin) begin
            bus.out_ready = ($urandom_range(99) < 32'(pct));
            ov_prev  = bus.out_valid && !bus.out_ready;
            prev_x   = bus.out_x;
            prev_idx = bus.out_idx;
            if (bus.out_valid && bus.out_ready) begin
               chk("out_x", 128'(bus.out_x), 128'(n_out < exp_q.size() ? exp_q[n_out] : '0));
               chk("out_idx", 128'(bus.out_idx), 128'(n_out));
               last_x = bus.out_x;
               n_out++;
               hs_cyc = cyc;
               if (n_out < ni) exp_tv = 1;
            end
            // Configuration churn and stray starts while busy must not disturb the run.
            bus.start    = ($urandom_range(7) == 0);
            bus.a_mat    = {9{$urandom}};
            bus.u_vec    = {$urandom, $urandom, $urandom};
            bus.x_init   = {$urandom, $urandom, $urandom};
            bus.n_warmup = 16'($urandom);
            bus.n_iter   = 16'($urandom);
         end
      end
      bus.start = 1'b0;
      bus.out_ready = 1'b0;
      chk("run_finished", 128'(fin), 128'(1));
      chk("no_timeout", 128'(bus.err_timeout), 128'(0));
      repeat (2) begin
         tick();
         chk("single_done", 128'(bus.done), 128'(0));
      end
   endtask

   initial begin
      vec_rec_t tbl[5];
      amat_t ai, ap, a2, ar;
      vec_t  lx;
      int    no, ntv, nd;

      ai = '0; ap = '0; a2 = '0;
      for (int i = 0; i < 3; i++) begin
         ai = set_e(ai, i, i, 32'd1);
         a2 = set_e(a2, i, i, 32'd2);
      end
      ap = set_e(ap, 0, 1, 32'd1);
      ap = set_e(ap, 1, 2, 32'd1);
      ap = set_e(ap, 2, 0, 32'd1);
      tbl[0] = '{'0, mk_vec(32'h3F800000, 32'h40000000, 32'h40400000), '0, 0, 3, 100,
                 mk_vec(32'h3F800000, 32'h40000000, 32'h40400000), 3};
      tbl[1] = '{ai, mk_vec(1, 2, 3), mk_vec(10, 20, 30), 2, 1, 100, mk_vec(13, 26, 39), 3};
      tbl[2] = '{ap, '0, mk_vec(5, 6, 7), 0, 3, 70, mk_vec(5, 6, 7), 3};
      tbl[3] = '{a2, '0, mk_vec(1, 2, 3), 3, 2, 50, mk_vec(32, 64, 96), 5};
      tbl[4] = '{ai, mk_vec(1, 1, 1), mk_vec(4, 4, 4), 2, 0, 100, '0, 0};

      reset = 1'b1;
      bus.start = 0; bus.abort = 0; bus.a_mat = '0; bus.u_vec = '0; bus.x_init = '0;
      bus.n_warmup = '0; bus.n_iter = '0; bus.dp_valid = 0; bus.dp_x_next = '0; bus.out_ready = 0;
      stub_on = 1; stub_junk = 0; stub_lat = 0; pend = 0; cd = 0;
      repeat (3) tick();
      chk_zero("reset");
      reset = 1'b0;
      tick();
      chk_zero("post_reset");

      foreach (tbl[t]) begin
         run_one(tbl[t].a, tbl[t].u, tbl[t].x, tbl[t].nw, tbl[t].ni, tbl[t].pct, lx, no, ntv, nd);
         chk($sformatf("tbl%0d_last_x", t), 128'(lx), 128'(tbl[t].exp_last));
         chk($sformatf("tbl%0d_n_out", t), 128'(no), 128'(tbl[t].ni));
         chk($sformatf("tbl%0d_n_tv", t), 128'(ntv), 128'(tbl[t].exp_tv));
         chk($sformatf("tbl%0d_n_done", t), 128'(nd), 128'(1));
      end

      // Datapath that never answers: watchdog fires 64 cycles after the issue strobe.
      stub_on = 0;
      bus.n_warmup = 0; bus.n_iter = 1; bus.start = 1;
      for (int c = 1; c <= 70; c++) begin
         tick();
         bus.start = 0;
         if (c == 1)  chk("to_tv", 128'(bus.dp_tvalid), 128'(1));
         if (c == 64) chk("to_err_early", 128'(bus.err_timeout), 128'(0));
         if (c == 65) begin
            chk("to_err", 128'(bus.err_timeout), 128'(1));
            chk("to_busy", 128'(bus.busy), 128'(0));
         end
         if (bus.done) chk("to_no_done", 128'(bus.done), 128'(0));
      end
      chk("to_err_sticky", 128'(bus.err_timeout), 128'(1));
      stub_on = 1;

      // Abort while waiting on a slow datapath; its late answer must be ignored.
      stub_lat = 6;
      bus.a_mat = ai; bus.u_vec = mk_vec(1, 1, 1); bus.x_init = '0;
      bus.n_warmup = 0; bus.n_iter = 2; bus.start = 1;
      tick(); bus.start = 0;
      tick(); bus.abort = 1;
      tick(); bus.abort = 0;
      chk("abort_busy", 128'(bus.busy), 128'(0));
      chk("abort_tv", 128'(bus.dp_tvalid), 128'(0));
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("abort_no_ov", 128'(bus.out_valid | bus.done), 128'(0));
      end
      bus.start = 1; bus.abort = 1;
      tick(); bus.start = 0; bus.abort = 0;
      chk("start_abort_idle", 128'(bus.busy | bus.dp_tvalid), 128'(0));
      stub_lat = 0;
      run_one(ai, mk_vec(1, 1, 1), '0, 0, 2, 100, lx, no, ntv, nd);
      chk("post_abort_last_x", 128'(lx), 128'(mk_vec(2, 2, 2)));
      chk("post_abort_n_out", 128'(no), 128'(2));

      // Reset in the middle of a run.
      stub_lat = 3;
      bus.n_warmup = 1; bus.n_iter = 3; bus.start = 1;
      tick(); bus.start = 0;
      repeat (4) tick();
      reset = 1;
      tick();
      chk_zero("mid_reset");
      reset = 0;
      tick();

      // Randomized runs against the reference model.
      stub_junk = 1;
      for (int r = 0; r < 8; r++) begin
         vec_t ur, xr;
         int nw, ni;
         ar = '0;
         for (int i = 0; i < 9; i++) ar[i*32 +: 32] = $urandom_range(0, 3);
         ur = {$urandom, $urandom, $urandom};
         xr = {$urandom, $urandom, $urandom};
         nw = $urandom_range(0, 4);
         ni = $urandom_range(1, 4);
         stub_lat = $urandom_range(0, 3);
         run_one(ar, ur, xr, nw, ni, $urandom_range(30, 100), lx, no, ntv, nd);
         chk("rnd_n_out", 128'(no), 128'(ni));
         chk("rnd_n_tv", 128'(ntv), 128'(nw + ni));
         chk("rnd_n_done", 128'(nd), 128'(1));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
